reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised successor register file for the CPU datapath: configurable data width and general-purpose register count, two asynchronous read ports, one synchronous write port, a per-bit-maskable flag register, and built-in PC increment and SP push/pop with bounds checking. It sits between the decode/ALU stage and memory-address logic. It replaces the single-port A/X/Y/SP/PC file and keeps that file's register encoding at default parameters.

## Interface
Parameters:
- DATA_W, 16, register and data width
- NUM_GPR, 3, general-purpose registers at indices 0..NUM_GPR-1 (0=A, 1=X, 2=Y)
- SEL_W, $clog2(NUM_GPR+2), register-select width; SP index = NUM_GPR, PC index = NUM_GPR+1
- SP_BASE, 16'hF000, SP reset value; empty-stack top
- SP_LIMIT, 16'hE000, lowest legal SP; full-stack bound
- PC_RESET, 16'h0000, PC reset value

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  register write strobe
- wr_sel  in  SEL_W  write target index
- wr_data  in  DATA_W  write data
- rd_sel_a / rd_sel_b  in  SEL_W  read selects
- rd_data_a / rd_data_b  out  DATA_W  read data
- flag_in  in  4  new flags {Z,N,C,O}, bit3..bit0
- flag_we  in  4  per-flag write mask
- flags_out  out  4  current flags {Z,N,C,O}
- pc_inc  in  1  PC += 1
- sp_push / sp_pop  in  1  SP -= 1 / SP += 1
- err_clr  in  1  clear sp_err
- sp_err  out  1  sticky stack overflow/underflow
- reg_a, reg_x, reg_y, reg_sp, reg_pc  out  DATA_W  debug taps of indices 0, 1, 2, SP, PC

## Operation
- Reset (rst=0, async): GPRs=0, SP=SP_BASE, PC=PC_RESET, flags=4'b0000, sp_err=0. All outputs reflect these values immediately.
- Write: at clk rise with wr_en=1, register[wr_sel] <= wr_data. A wr_sel above NUM_GPR+1 is ignored.
- Read: rd_data_x = register[rd_sel_x], combinational. An out-of-range select returns 0.
- Flags: for each bit i with flag_we[i]=1, flags[i] <= flag_in[i] at clk rise. Other bits hold.
- PC: pc_inc adds 1 modulo 2^DATA_W (0xFFFF -> 0x0000). A same-cycle wr_en to PC wins and the increment is dropped.
- SP push: if SP==SP_LIMIT, SP holds and sp_err<=1; otherwise SP<=SP-1.
- SP pop: if SP==SP_BASE, SP holds and sp_err<=1; otherwise SP<=SP+1.
- push and pop together: SP holds, no error.
- wr_en to SP: the write wins over push/pop and no error is raised.
- sp_err: sticky. err_clr clears it. A new error in the same cycle as err_clr wins (sp_err stays 1).
- Reset mid-operation forces reset values asynchronously. Pending strobes are discarded.

## Timing
- Read latency 0 (combinational). Write, flag, PC and SP updates are visible one cycle after the clk rise that samples them.
- No handshake. Strobes are level, sampled every rising edge. Holding pc_inc high for N cycles adds N.
- rst is deasserted synchronously to clk by the upstream reset synchroniser.

## Configuration
- REG_BANK_BYPASS_EN defined: when wr_en=1 and rd_sel_x==wr_sel (in range), rd_data_x = wr_data in the same cycle (write-to-read forwarding on both ports). Bypass covers explicit writes only, not pc_inc or push/pop.
- Not defined: reads return the stored value. New data appears the cycle after the write.

## Structure
- Package reg_bank_pkg holds:
  - index constants REG_A=0, REG_X=1, REG_Y=2
  - flag bit positions FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_O=0
  - an SP/PC index function of NUM_GPR
- Sub-module sp_ctrl contains the SP register, push/pop arithmetic, bounds compare, write-override priority and sticky sp_err.
- GPRs, PC, flags and read muxes live in reg_bank.

## Test plan
- Reset: drive rst=0 mid-cycle -> outputs immediately A/X/Y=0, SP=F000, PC=0000, flags=0000, sp_err=0.
- Write 1234/5678/9ABC to indices 0/1/2, then read on both ports with rd_sel_a=0, rd_sel_b=2 -> rd_data_a=1234, rd_data_b=9ABC. Write to index 7 is ignored and a read of index 7 returns 0000.
- flag_in=1010, flag_we=1111 -> flags 1010. Then flag_in=0101, flag_we=0011 -> flags 1001.
- PC=FFFF then pc_inc -> 0000. Same cycle pc_inc plus write of 1000 to PC -> PC=1000.
- SP=F000 plus pop -> SP holds, sp_err=1. err_clr -> 0. Two pushes -> EFFE. Write E000 then push -> SP holds at E000, sp_err=1.
- Same-cycle write of 00AA to A with rd_sel_a=0 -> rd_data_a=00AA with REG_BANK_BYPASS_EN defined, previous value without it.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared register-bank constants: GPR indices, flag bit positions, SP/PC index helpers.
package reg_bank_pkg;

   localparam int REG_A = 0;
   localparam int REG_X = 1;
   localparam int REG_Y = 2;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_O = 0;

   // SP and PC sit directly above the general-purpose registers.
   function automatic int sp_idx(input int num_gpr);
      return num_gpr;
   endfunction

   function automatic int pc_idx(input int num_gpr);
      return num_gpr + 1;
   endfunction

endpackage

// File: rtl/reg_bank_sp_ctrl.sv
// Stack pointer with bounded push/pop, write override and sticky sp_err.
// Latency: updates visible one cycle after the sampling edge; no backpressure, strobes are level.
module sp_ctrl #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] SP_BASE  = 16'hF000,
   parameter logic [DATA_W-1:0] SP_LIMIT = 16'hE000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              push,
   input  logic              pop,
   input  logic              err_clr,
   output logic [DATA_W-1:0] sp,
   output logic              sp_err
);

   logic [DATA_W-1:0] sp_nxt;
   logic              err_set;

   // An explicit write masks push/pop entirely, so it can never raise an error.
   always_comb begin
      sp_nxt  = sp;
      err_set = 1'b0;
      if (wr) begin
         sp_nxt = wr_data;
      end else if (push && !pop) begin
         if (sp == SP_LIMIT) err_set = 1'b1;
         else                sp_nxt  = sp - 1'b1;
      end else if (pop && !push) begin
         if (sp == SP_BASE) err_set = 1'b1;
         else               sp_nxt  = sp + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp     <= SP_BASE;
         sp_err <= 1'b0;
      end else begin
         sp <= sp_nxt;
         if (err_set)      sp_err <= 1'b1;
         else if (err_clr) sp_err <= 1'b0;
      end
   end

endmodule

// File: rtl/reg_bank.sv
// Register file: GPRs, SP, PC, maskable flags; 2 async read ports, 1 sync write port, no backpressure.
// Optional REG_BANK_BYPASS_EN forwards same-cycle write data to both read ports.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                NUM_GPR  = 3,
   parameter int                SEL_W    = $clog2(NUM_GPR + 2),
   parameter logic [DATA_W-1:0] SP_BASE  = 16'hF000,
   parameter logic [DATA_W-1:0] SP_LIMIT = 16'hE000,
   parameter logic [DATA_W-1:0] PC_RESET = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [SEL_W-1:0]  wr_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [SEL_W-1:0]  rd_sel_a,
   input  logic [SEL_W-1:0]  rd_sel_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [3:0]        flag_in,
   input  logic [3:0]        flag_we,
   output logic [3:0]        flags_out,
   input  logic              pc_inc,
   input  logic              sp_push,
   input  logic              sp_pop,
   input  logic              err_clr,
   output logic              sp_err,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_x,
   output logic [DATA_W-1:0] reg_y,
   output logic [DATA_W-1:0] reg_sp,
   output logic [DATA_W-1:0] reg_pc
);

   localparam int               SP_IDX = sp_idx(NUM_GPR);
   localparam int               PC_IDX = pc_idx(NUM_GPR);
   localparam int               N_REGS = NUM_GPR + 2;
   localparam logic [SEL_W-1:0] SP_SEL = SEL_W'(SP_IDX);
   localparam logic [SEL_W-1:0] PC_SEL = SEL_W'(PC_IDX);

   logic [DATA_W-1:0] gpr  [NUM_GPR];
   logic [DATA_W-1:0] regs [N_REGS];
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] sp;
   logic [3:0]        flags;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++)
            if (wr_en && wr_sel == SEL_W'(i)) gpr[i] <= wr_data;
      end
   end

   // An explicit PC write takes priority; the increment that cycle is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           pc <= PC_RESET;
      else if (wr_en && wr_sel == PC_SEL) pc <= wr_data;
      else if (pc_inc)                    pc <= pc + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) flags <= 4'b0000;
      else      flags <= (flags & ~flag_we) | (flag_in & flag_we);
   end

   sp_ctrl #(
      .DATA_W   (DATA_W),
      .SP_BASE  (SP_BASE),
      .SP_LIMIT (SP_LIMIT)
   ) u_sp_ctrl (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_en && wr_sel == SP_SEL),
      .wr_data (wr_data),
      .push    (sp_push),
      .pop     (sp_pop),
      .err_clr (err_clr),
      .sp      (sp),
      .sp_err  (sp_err)
   );

   always_comb begin
      for (int i = 0; i < NUM_GPR; i++) regs[i] = gpr[i];
      regs[SP_IDX] = sp;
      regs[PC_IDX] = pc;
   end

   // Selects beyond PC match no entry and read as zero.
   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (rd_sel_a == SEL_W'(i)) rd_data_a = regs[i];
         if (rd_sel_b == SEL_W'(i)) rd_data_b = regs[i];
      end
`ifdef REG_BANK_BYPASS_EN
      if (wr_en && wr_sel <= PC_SEL && rd_sel_a == wr_sel) rd_data_a = wr_data;
      if (wr_en && wr_sel <= PC_SEL && rd_sel_b == wr_sel) rd_data_b = wr_data;
`else
`endif
   end

   assign flags_out = flags;
   assign reg_a     = gpr[REG_A];
   assign reg_x     = gpr[REG_X];
   assign reg_y     = gpr[REG_Y];
   assign reg_sp    = sp;
   assign reg_pc    = pc;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: spec-level model checked every negedge plus literal expectations.
module tb_reg_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_sel = '0;
   logic [15:0] wr_data = '0;
   logic [2:0]  rd_sel_a = '0;
   logic [2:0]  rd_sel_b = '0;
   logic [15:0] rd_data_a, rd_data_b;
   logic [3:0]  flag_in = '0;
   logic [3:0]  flag_we = '0;
   logic [3:0]  flags_out;
   logic        pc_inc = 1'b0;
   logic        sp_push = 1'b0;
   logic        sp_pop = 1'b0;
   logic        err_clr = 1'b0;
   logic        sp_err;
   logic [15:0] reg_a, reg_x, reg_y, reg_sp, reg_pc;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   reg_bank dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .flag_in(flag_in), .flag_we(flag_we), .flags_out(flags_out),
      .pc_inc(pc_inc), .sp_push(sp_push), .sp_pop(sp_pop), .err_clr(err_clr), .sp_err(sp_err),
      .reg_a(reg_a), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp), .reg_pc(reg_pc)
   );

   always #5 clk = ~clk;

   // Architectural model: plain array of A/X/Y/SP/PC, flags and error bit.
   logic [15:0] m_reg [5];
   logic [3:0]  m_flags;
   bit          m_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_reg[0] = 16'h0; m_reg[1] = 16'h0; m_reg[2] = 16'h0;
         m_reg[3] = 16'hF000; m_reg[4] = 16'h0000;
         m_flags = 4'b0000; m_err = 1'b0;
      end else begin
         bit new_err;
         new_err = 1'b0;
         for (int i = 0; i < 4; i++) if (flag_we[i]) m_flags[i] = flag_in[i];
         if (pc_inc && !(wr_en && wr_sel == 3'd4)) m_reg[4] = m_reg[4] + 16'd1;
         if (!(wr_en && wr_sel == 3'd3)) begin
            if (sp_push && !sp_pop) begin
               if (m_reg[3] == 16'hE000) new_err = 1'b1; else m_reg[3] = m_reg[3] - 16'd1;
            end else if (sp_pop && !sp_push) begin
               if (m_reg[3] == 16'hF000) new_err = 1'b1; else m_reg[3] = m_reg[3] + 16'd1;
            end
         end
         if (wr_en && wr_sel <= 3'd4) m_reg[wr_sel] = wr_data;
         if (new_err) m_err = 1'b1; else if (err_clr) m_err = 1'b0;
      end
   end

   function automatic logic [15:0] m_read(input logic [2:0] sel);
      logic [15:0] v;
      v = (sel <= 3'd4) ? m_reg[sel] : 16'h0000;
`ifdef REG_BANK_BYPASS_EN
      if (wr_en && wr_sel <= 3'd4 && sel == wr_sel) v = wr_data;
`endif
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("m.rd_a", rd_data_a, m_read(rd_sel_a));
         check("m.rd_b", rd_data_b, m_read(rd_sel_b));
         check("m.a", reg_a, m_reg[0]);
         check("m.x", reg_x, m_reg[1]);
         check("m.y", reg_y, m_reg[2]);
         check("m.sp", reg_sp, m_reg[3]);
         check("m.pc", reg_pc, m_reg[4]);
         check("m.flags", {12'h0, flags_out}, {12'h0, m_flags});
         check("m.err", {15'h0, sp_err}, {15'h0, m_err});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; pc_inc = 0; sp_push = 0; sp_pop = 0; err_clr = 0; flag_we = 4'b0000;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [15:0] d);
      wr_en = 1; wr_sel = sel; wr_data = d;
   endtask

   initial begin
      #1 rst = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      chk_en = 1;

      wr(3'd0, 16'h1234); cyc();
      wr(3'd1, 16'h5678); cyc();
      wr(3'd2, 16'h9ABC); cyc();
      idle(); rd_sel_a = 3'd0; rd_sel_b = 3'd2; #1;
      check("rd_a_gpr0", rd_data_a, 16'h1234);
      check("rd_b_gpr2", rd_data_b, 16'h9ABC);

      wr(3'd7, 16'hDEAD); cyc();
      idle(); rd_sel_a = 3'd7; rd_sel_b = 3'd3; #1;
      check("rd_idx7", rd_data_a, 16'h0000);
      check("rd_sp", rd_data_b, 16'hF000);
      check("x_kept", reg_x, 16'h5678);

      flag_in = 4'b1010; flag_we = 4'b1111; cyc();
      idle(); #1;
      check("flags_all", {12'h0, flags_out}, 16'h000A);
      flag_in = 4'b0101; flag_we = 4'b0011; cyc();
      idle(); #1;
      check("flags_mask", {12'h0, flags_out}, 16'h0009);

      wr(3'd4, 16'hFFFF); cyc();
      idle(); pc_inc = 1; cyc();
      idle(); #1;
      check("pc_wrap", reg_pc, 16'h0000);
      pc_inc = 1; wr(3'd4, 16'h1000); cyc();
      wr_en = 0; cyc(); cyc(); cyc();
      idle(); #1;
      check("pc_wr_then_3inc", reg_pc, 16'h1003);

      sp_pop = 1; cyc();
      idle(); #1;
      check("sp_pop_empty", reg_sp, 16'hF000);
      check("err_underflow", {15'h0, sp_err}, 16'h0001);
      err_clr = 1; cyc();
      idle(); #1;
      check("err_clr", {15'h0, sp_err}, 16'h0000);
      sp_push = 1; cyc(); cyc();
      idle(); #1;
      check("sp_push2", reg_sp, 16'hEFFE);
      sp_push = 1; sp_pop = 1; cyc();
      idle(); #1;
      check("sp_pushpop", reg_sp, 16'hEFFE);
      wr(3'd3, 16'hE000); sp_push = 1; cyc();
      idle(); #1;
      check("sp_wr_wins", reg_sp, 16'hE000);
      check("sp_wr_noerr", {15'h0, sp_err}, 16'h0000);
      sp_push = 1; cyc();
      idle(); #1;
      check("sp_full", reg_sp, 16'hE000);
      check("err_overflow", {15'h0, sp_err}, 16'h0001);
      sp_push = 1; err_clr = 1; cyc();
      idle(); #1;
      check("err_set_beats_clr", {15'h0, sp_err}, 16'h0001);
      sp_pop = 1; cyc();
      idle(); #1;
      check("sp_pop", reg_sp, 16'hE001);

      rd_sel_a = 3'd0; wr(3'd0, 16'h00AA); #1;
`ifdef REG_BANK_BYPASS_EN
      check("bypass_rd", rd_data_a, 16'h00AA);
`else
      check("no_bypass_rd", rd_data_a, 16'h1234);
`endif
      cyc();
      idle(); #1;
      check("a_written", reg_a, 16'h00AA);

      pc_inc = 1; sp_push = 1; wr(3'd1, 16'h7777);
      #2 rst = 0; #1;
      check("rst_a", reg_a, 16'h0000);
      check("rst_x", reg_x, 16'h0000);
      check("rst_sp", reg_sp, 16'hF000);
      check("rst_pc", reg_pc, 16'h0000);
      check("rst_flags", {12'h0, flags_out}, 16'h0000);
      check("rst_err", {15'h0, sp_err}, 16'h0000);
      cyc();
      check("rst_hold_pc", reg_pc, 16'h0000);
      idle(); rst = 1; rd_sel_b = 3'd4;
      cyc(); cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
